rom_fetch_unit: RTL and testbench

- Fetch-side initiator for the synchronous-read instruction ROM (ADDR sampled on CLK rising edge, DATA valid the following cycle).
- Owns the fetch program counter and drives the ROM address bus.
- Compensates for the 1-cycle ROM read latency and buffers fetched bytes in a small FIFO, tagged with their addresses.
- Hands the buffered instructions to the processor decode stage through a valid/ready handshake; supports redirect (jump) with flush.

---
 rtl/rom_fetch_unit.sv | 105 ++++++++++
 tb/tb_rom_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// Fetch-side initiator for a synchronous-read instruction ROM: owns the fetch PC,
// hides the one-cycle read latency and buffers address-tagged bytes for decode.
module rom_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          FETCH_EN,
  input  logic                          JUMP,
  input  logic [ADDR_WIDTH-1:0]         JUMP_ADDR,
  output logic [ADDR_WIDTH-1:0]         ROM_ADDR,
  input  logic [DATA_WIDTH-1:0]         ROM_DATA,
  output logic [DATA_WIDTH-1:0]         INSTR,
  output logic [ADDR_WIDTH-1:0]         INSTR_ADDR,
  output logic                          INSTR_VALID,
  input  logic                          INSTR_READY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_addr;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];

  logic [SUM_W-1:0]      occupancy_c;
  logic                  issue_c;
  logic                  push_c;
  logic                  pop_c;

  // Credit check counts the inflight read so a returning byte always has a slot;
  // a same-cycle pop is deliberately not credited.
  always_comb begin
    occupancy_c = SUM_W'(count) + SUM_W'(inflight);
    issue_c     = FETCH_EN & ~JUMP & (occupancy_c < SUM_W'(FIFO_DEPTH));
    push_c      = inflight & ~JUMP;
    pop_c       = (count != '0) & INSTR_READY & ~JUMP;
  end

  // Fetch PC and the one-deep record of the read currently in the ROM.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc            <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (JUMP) begin
      pc       <= JUMP_ADDR;
      inflight <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        pc            <= pc + ADDR_WIDTH'(1);
        inflight_addr <= pc;
      end
    end
  end

  // Tagged byte buffer; a redirect empties it by rewinding the pointers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else if (JUMP) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        mem_data[wr_ptr] <= ROM_DATA;
        mem_addr[wr_ptr] <= inflight_addr;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign ROM_ADDR    = pc;
  assign INSTR       = mem_data[rd_ptr];
  assign INSTR_ADDR  = mem_addr[rd_ptr];
  assign INSTR_VALID = (count != '0);
  assign COUNT       = count;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: directed scenarios plus a randomized
// run against a queue-based model of the fetch buffer.
module tb_rom_fetch_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FETCH_EN = 1'b0;
  logic       JUMP = 1'b0;
  logic [7:0] JUMP_ADDR = 8'h00;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [7:0] INSTR;
  logic [7:0] INSTR_ADDR;
  logic       INSTR_VALID;
  logic       INSTR_READY = 1'b0;
  logic [2:0] COUNT;

  int checks = 0;
  int errors = 0;

  // Reference model: program counter, one pending read and a queue of addresses.
  logic [7:0] m_q[$];
  logic [7:0] m_pc;
  logic       m_inf;
  logic [7:0] m_ia;

  rom_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .FETCH_EN(FETCH_EN), .JUMP(JUMP),
    .JUMP_ADDR(JUMP_ADDR), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .INSTR(INSTR), .INSTR_ADDR(INSTR_ADDR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read ROM with contents ROM[i] = i ^ 8'hA5.
  always @(posedge CLK) ROM_DATA <= ROM_ADDR ^ 8'hA5;

  task automatic m_reset();
    m_q.delete();
    m_pc  = 8'h00;
    m_inf = 1'b0;
    m_ia  = 8'h00;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic step();
    int occ;
    bit iss;
    @(posedge CLK);
    if (!RESET) begin
      if (JUMP) begin
        m_q.delete();
        m_pc  = JUMP_ADDR;
        m_inf = 1'b0;
      end else begin
        occ = m_q.size() + (m_inf ? 1 : 0);
        iss = FETCH_EN && (occ < 4);
        if (m_q.size() > 0 && INSTR_READY) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_ia);
        if (iss) begin
          m_ia = m_pc;
          m_pc = m_pc + 8'd1;
        end
        m_inf = iss;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    m_reset();
    #2;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #12;
    m_reset();
    checks++; if (ROM_ADDR !== 8'h00) begin errors++; $display("FAIL reset_rom_addr got %h exp 00", ROM_ADDR); end
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", INSTR_VALID); end
    checks++; if (INSTR !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", INSTR); end
    checks++; if (INSTR_ADDR !== 8'h00) begin errors++; $display("FAIL reset_instr_addr got %h exp 00", INSTR_ADDR); end
    step();
  endtask

  task automatic test_stream();
    logic [7:0] e;
    FETCH_EN = 1'b1; INSTR_READY = 1'b1; JUMP = 1'b0;
    apply_reset();
    step();
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL stream_valid_early got %b exp 0", INSTR_VALID); end
    checks++; if (ROM_ADDR !== 8'h01) begin errors++; $display("FAIL stream_rom_addr got %h exp 01", ROM_ADDR); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(); else step();
      e = 8'(i);
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_ADDR !== e || INSTR !== (e ^ 8'hA5)) begin
        errors++;
        $display("FAIL stream_beat%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, INSTR_VALID, INSTR_ADDR, INSTR, e, e ^ 8'hA5);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] e;
    FETCH_EN = 1'b1; INSTR_READY = 1'b0; JUMP = 1'b0;
    apply_reset();
    for (int i = 0; i < 7; i++) step();
    checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", COUNT); end
    checks++; if (ROM_ADDR !== 8'h04) begin errors++; $display("FAIL bp_rom_addr got %h exp 04", ROM_ADDR); end
    checks++; if (INSTR !== 8'hA5 || INSTR_ADDR !== 8'h00) begin errors++; $display("FAIL bp_head got a=%h d=%h exp a=00 d=a5", INSTR_ADDR, INSTR); end
    INSTR_READY = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      if (INSTR_VALID === 1'b1) begin
        e = 8'(n);
        checks++;
        if (INSTR_ADDR !== e || INSTR !== (e ^ 8'hA5)) begin
          errors++;
          $display("FAIL bp_drain%0d got a=%h d=%h exp a=%h d=%h", n, INSTR_ADDR, INSTR, e, e ^ 8'hA5);
        end
        n++;
      end
      step();
    end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_drain_timeout got %0d exp 8", n); end
  endtask

  task automatic test_jump();
    FETCH_EN = 1'b1; INSTR_READY = 1'b0; JUMP = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    checks++; if (COUNT !== 3'd3) begin errors++; $display("FAIL jump_pre_count got %0d exp 3", COUNT); end
    JUMP = 1'b1; JUMP_ADDR = 8'h80;
    step();
    JUMP = 1'b0;
    checks++;
    if (COUNT !== 3'd0 || INSTR_VALID !== 1'b0 || ROM_ADDR !== 8'h80) begin
      errors++;
      $display("FAIL jump_flush got c=%0d v=%b ra=%h exp c=0 v=0 ra=80", COUNT, INSTR_VALID, ROM_ADDR);
    end
    INSTR_READY = 1'b1;
    step();
    checks++; if (INSTR_VALID !== 1'b0 || ROM_ADDR !== 8'h81) begin errors++; $display("FAIL jump_issue got v=%b ra=%h exp v=0 ra=81", INSTR_VALID, ROM_ADDR); end
    step();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_ADDR !== 8'h80 || INSTR !== 8'h25) begin
      errors++;
      $display("FAIL jump_first got v=%b a=%h d=%h exp v=1 a=80 d=25", INSTR_VALID, INSTR_ADDR, INSTR);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    FETCH_EN = 1'b1; INSTR_READY = 1'b1; JUMP = 1'b0;
    apply_reset();
    step();
    JUMP = 1'b1; JUMP_ADDR = 8'hFE;
    step();
    JUMP = 1'b0;
    checks++; if (ROM_ADDR !== 8'hFE) begin errors++; $display("FAIL wrap_rom_addr got %h exp fe", ROM_ADDR); end
    step();
    step();
    checks++; if (ROM_ADDR !== 8'h00) begin errors++; $display("FAIL wrap_rom_addr_wrapped got %h exp 00", ROM_ADDR); end
    e = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_ADDR !== e || INSTR !== (e ^ 8'hA5)) begin
        errors++;
        $display("FAIL wrap_beat%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, INSTR_VALID, INSTR_ADDR, INSTR, e, e ^ 8'hA5);
      end
      e = e + 8'd1;
      step();
    end
  endtask

  task automatic test_fetch_en();
    FETCH_EN = 1'b1; INSTR_READY = 1'b1; JUMP = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) step();
    checks++; if (ROM_ADDR !== 8'h06) begin errors++; $display("FAIL fe_pre_rom_addr got %h exp 06", ROM_ADDR); end
    FETCH_EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (ROM_ADDR !== 8'h06) begin errors++; $display("FAIL fe_hold%0d got %h exp 06", k, ROM_ADDR); end
      if (k == 0) begin
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR_ADDR !== 8'h05) begin
          errors++;
          $display("FAIL fe_inflight got v=%b a=%h exp v=1 a=05", INSTR_VALID, INSTR_ADDR);
        end
      end else begin
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL fe_drained%0d got %b exp 0", k, INSTR_VALID); end
      end
    end
    FETCH_EN = 1'b1;
    step();
    step();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_ADDR !== 8'h06 || INSTR !== 8'hA3) begin
      errors++;
      $display("FAIL fe_resume got v=%b a=%h d=%h exp v=1 a=06 d=a3", INSTR_VALID, INSTR_ADDR, INSTR);
    end
  endtask

  task automatic test_async_reset();
    FETCH_EN = 1'b1; INSTR_READY = 1'b1; JUMP = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (ROM_ADDR !== 8'h00 || COUNT !== 3'd0 || INSTR_VALID !== 1'b0 || INSTR !== 8'h00 || INSTR_ADDR !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got ra=%h c=%0d v=%b d=%h a=%h exp all zero", ROM_ADDR, COUNT, INSTR_VALID, INSTR, INSTR_ADDR);
    end
    m_reset();
    step();
    RESET = 1'b0;
    step();
    step();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_ADDR !== 8'h00 || INSTR !== 8'hA5) begin
      errors++;
      $display("FAIL async_restart got v=%b a=%h d=%h exp v=1 a=00 d=a5", INSTR_VALID, INSTR_ADDR, INSTR);
    end
  endtask

  task automatic test_random();
    logic [7:0] h;
    JUMP = 1'b0; FETCH_EN = 1'b1; INSTR_READY = 1'b1;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      FETCH_EN    = ($urandom_range(0, 9) < 8);
      INSTR_READY = ($urandom_range(0, 9) < 6);
      JUMP        = ($urandom_range(0, 19) == 0);
      JUMP_ADDR   = 8'($urandom);
      step();
      checks++;
      if (COUNT !== 3'(m_q.size()) || ROM_ADDR !== m_pc || INSTR_VALID !== (m_q.size() > 0)) begin
        errors++;
        $display("FAIL rand_state cyc %0d got c=%0d ra=%h v=%b exp c=%0d ra=%h v=%b",
                 cyc, COUNT, ROM_ADDR, INSTR_VALID, m_q.size(), m_pc, (m_q.size() > 0));
      end
      if (m_q.size() > 0) begin
        h = m_q[0];
        checks++;
        if (INSTR_ADDR !== h || INSTR !== (h ^ 8'hA5)) begin
          errors++;
          $display("FAIL rand_head cyc %0d got a=%h d=%h exp a=%h d=%h", cyc, INSTR_ADDR, INSTR, h, h ^ 8'hA5);
        end
      end
    end
    JUMP = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_fetch_en();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
